// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the PC sequencer.
// State encoding, field widths and the link register index.
package pc_sequencer_pkg;

    localparam int PC_W     = 32;
    localparam int T_W      = 27;
    localparam int N_W      = 17;
    localparam int LINK_REG = 31;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } seq_state_t;

    // Widen the N field to a full PC offset, keeping its sign.
    function automatic logic [PC_W-1:0] sext_imm(
        input logic [N_W-1:0] v
    );
        return {{(PC_W-N_W){v[N_W-1]}}, v};
    endfunction

    // Widen the T field to a full PC, filling with zeros.
    function automatic logic [PC_W-1:0] zext_tgt(
        input logic [T_W-1:0] v
    );
        return {{(PC_W-T_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Control-transfer target selection for the PC sequencer.
// Priority mux over jr / jump / branch plus the branch adder.
module pc_target_sel
    import pc_sequencer_pkg::*;
(
    input  logic            run,
    input  logic            jp,
    input  logic            br,
    input  logic            jal,
    input  logic            jr,
    input  logic            bex,
    input  logic            rstatus_nz,
    input  logic [T_W-1:0]  target,
    input  logic [N_W-1:0]  imm,
    input  logic [PC_W-1:0] rd_val,
    input  logic [PC_W-1:0] pc_d,
    output logic            taken,
    output logic [PC_W-1:0] tgt
);

    logic            jump;
    logic [PC_W-1:0] br_tgt;

    // jal is always decoded together with jp; either one marks a jump.
    assign jump   = jp | jal;
    assign br_tgt = pc_d + PC_W'(1) + sext_imm(imm);

    // Priority pick; an untaken bex still blocks the branch term.
    always_comb begin
        taken = 1'b0;
        tgt   = '0;
        if (run) begin
            if (jr) begin
                taken = 1'b1;
                tgt   = rd_val;
            end else if (jump) begin
                taken = bex ? rstatus_nz : 1'b1;
                tgt   = zext_tgt(target);
            end else if (br) begin
                taken = 1'b1;
                tgt   = br_tgt;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode program counter sequencer.
// Holds pc, pc_d and the RUN/BUBBLE state; squashes one slot on redirect.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            jp,
    input  logic            br,
    input  logic            jal,
    input  logic            jr,
    input  logic            bex,
    input  logic            rstatus_nz,
    input  logic [T_W-1:0]  target,
    input  logic [N_W-1:0]  imm,
    input  logic [PC_W-1:0] rd_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_d,
    output logic [PC_W-1:0] link,
    output logic            inst_valid,
    output logic            redirect
);

    seq_state_t      state;
    logic            run;
    logic            taken;
    logic [PC_W-1:0] tgt;

    assign run        = (state == RUN);
    assign inst_valid = run;
    assign redirect   = taken;
    assign link       = pc_d + PC_W'(1);

    pc_target_sel u_sel (
        .run        (run),
        .jp         (jp),
        .br         (br),
        .jal        (jal),
        .jr         (jr),
        .bex        (bex),
        .rstatus_nz (rstatus_nz),
        .target     (target),
        .imm        (imm),
        .rd_val     (rd_val),
        .pc_d       (pc_d),
        .taken      (taken),
        .tgt        (tgt)
    );

    // Advance fetch/decode on enabled edges; a redirect inserts one bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= '0;
            pc_d  <= '0;
            state <= BUBBLE;
        end else if (en) begin
            pc_d <= pc;
            if (taken) begin
                pc    <= tgt;
                state <= BUBBLE;
            end else begin
                pc    <= pc + PC_W'(1);
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Vector table plus hand sequences, expected state via a scoreboard queue.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        jp, br, jal, jr, bex;
    logic        rstatus_nz;
    logic [26:0] target;
    logic [16:0] imm;
    logic [31:0] rd_val;
    logic [31:0] pc, pc_d, link;
    logic        inst_valid, redirect;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] JP   = 5'b10000;
    localparam logic [4:0] BR   = 5'b01000;
    localparam logic [4:0] JAL  = 5'b00100;
    localparam logic [4:0] JR   = 5'b00010;
    localparam logic [4:0] BEX  = 5'b00001;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  ctl;
        logic        rnz;
        logic [26:0] tgt;
        logic [16:0] imm;
        logic [31:0] rdv;
        logic        e_red;
        logic        e_ivpre;
        logic [31:0] e_link;
        logic [31:0] e_pc;
        logic [31:0] e_pcd;
        logic        e_iv;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcd;
        logic        iv;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    pc_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .jp         (jp),
        .br         (br),
        .jal        (jal),
        .jr         (jr),
        .bex        (bex),
        .rstatus_nz (rstatus_nz),
        .target     (target),
        .imm        (imm),
        .rd_val     (rd_val),
        .pc         (pc),
        .pc_d       (pc_d),
        .link       (link),
        .inst_valid (inst_valid),
        .redirect   (redirect)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic        rst,
        input logic        e,
        input logic [4:0]  ctl,
        input logic        rnz,
        input logic [26:0] tg,
        input logic [16:0] im,
        input logic [31:0] rdv,
        input logic        red,
        input logic        ivpre,
        input logic [31:0] lnk,
        input logic [31:0] epc,
        input logic [31:0] epcd,
        input logic        eiv
    );
        vec_t v;
        v.rst = rst; v.en = e; v.ctl = ctl; v.rnz = rnz;
        v.tgt = tg; v.imm = im; v.rdv = rdv;
        v.e_red = red; v.e_ivpre = ivpre; v.e_link = lnk;
        v.e_pc = epc; v.e_pcd = epcd; v.e_iv = eiv;
        return v;
    endfunction

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset      = v.rst;
        en         = v.en;
        {jp, br, jal, jr, bex} = v.ctl;
        rstatus_nz = v.rnz;
        target     = v.tgt;
        imm        = v.imm;
        rd_val     = v.rdv;
        #1;
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, v.e_red});
        chk({tag, ".iv_pre"}, {31'd0, inst_valid}, {31'd0, v.e_ivpre});
        chk({tag, ".link"}, link, v.e_link);
        e.pc  = v.e_pc;
        e.pcd = v.e_pcd;
        e.iv  = v.e_iv;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk({tag, ".pc"}, pc, got.pc);
        chk({tag, ".pc_d"}, pc_d, got.pcd);
        chk({tag, ".iv"}, {31'd0, inst_valid}, {31'd0, got.iv});
    endtask

    initial begin
        reset = 1'b1; en = 1'b0;
        {jp, br, jal, jr, bex} = NONE;
        rstatus_nz = 1'b0; target = '0; imm = '0; rd_val = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.pc", pc, 32'd0);
        chk("rst.pc_d", pc_d, 32'd0);
        chk("rst.iv", {31'd0, inst_valid}, 32'd0);
        chk("rst.redirect", {31'd0, redirect}, 32'd0);

        // sequential run from reset
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,0,1,  1,0,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,1,  2,1,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,2,  3,2,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,3,  4,3,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,4,  5,4,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,5,  6,5,1));
        // jal at pc_d=5
        tbl.push_back(mk(0,1,JP|JAL,0,27'h100,0,0, 1,1,6, 32'h100,6,0));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,0,7, 32'h101,32'h100,1));
        // jump to 9 to reach pc_d=10
        tbl.push_back(mk(0,1,JP,0,9,0,0, 1,1,32'h101, 9,32'h101,0));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,0,32'h102, 10,9,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,10, 11,10,1));
        // backward branch from pc_d=10
        tbl.push_back(mk(0,1,BR,0,0,17'h1FFFD,0, 1,1,11, 8,11,0));
        // branch held high in bubble is ignored
        tbl.push_back(mk(0,1,BR,0,0,17'h1FFFD,0, 0,0,12, 9,8,1));
        // jump to 7
        tbl.push_back(mk(0,1,JP,0,7,0,0, 1,1,9, 7,9,0));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,0,10, 8,7,1));
        // bex not taken also blocks br
        tbl.push_back(mk(0,1,JP|BEX|BR,0,40,17'h5,0, 0,1,8, 9,8,1));
        tbl.push_back(mk(0,1,JP|BEX,1,40,0,0, 1,1,9, 40,9,0));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,0,10, 41,40,1));
        // jr wins; first edge stalled
        tbl.push_back(mk(0,0,JR|JP|BEX|BR,0,3,17'h2,32'hFFFFFFFF,
                         1,1,41, 41,40,1));
        tbl.push_back(mk(0,1,JR|JP|BEX|BR,0,3,17'h2,32'hFFFFFFFF,
                         1,1,41, 32'hFFFFFFFF,41,0));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,0,42, 0,32'hFFFFFFFF,1));
        tbl.push_back(mk(0,1,NONE,0,0,0,0, 0,1,0, 1,0,1));
        tbl.push_back(mk(0,0,NONE,0,0,0,0, 0,1,1, 1,0,1));

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("v%0d", i), tbl[i]);

        // reset the cycle after a redirect
        apply("rr0", mk(0,1,JP,0,27'h55,0,0, 1,1,1, 32'h55,1,0));
        apply("rr1", mk(1,1,NONE,0,0,0,0, 0,0,2, 0,0,0));
        apply("rr2", mk(0,1,NONE,0,0,0,0, 0,0,1, 1,0,1));
        // reset during a stalled redirect
        apply("rs0", mk(0,1,NONE,0,0,0,0, 0,1,1, 2,1,1));
        apply("rs1", mk(1,0,JP,0,27'h77,0,0, 1,1,2, 0,0,0));
        apply("rs2", mk(0,1,NONE,0,0,0,0, 0,0,1, 1,0,1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The clock SHALL be `clock`, input, 1 bit; all state SHALL update on its rising edge.
REQ-002 The reset SHALL be `reset`, input, 1 bit; reset is synchronous and active-high.
REQ-003 `en`, input, 1: advance enable. When 0, the block stalls and drives the imem clock-enable.
REQ-004 `jp`, `br`, `jal`, `jr`, `bex`, inputs, 1 each: control-decoder outputs for the instruction at `pc_d`.
REQ-005 `rstatus_nz`, input, 1: $rstatus != 0.
REQ-006 `target`, input, 27: instruction T field.
REQ-007 `imm`, input, 17: instruction N field.
REQ-008 `rd_val`, input, 32: $rd read value for jr.
REQ-009 `pc`, output, 32: imem address; the instruction appears on the imem output one enabled cycle later.
REQ-010 `pc_d`, output, 32: address of the instruction currently in decode.
REQ-011 `link`, output, 32: `pc_d`+1, the value written to $r31 on jal.
REQ-012 `inst_valid`, output, 1: the decode-stage instruction is on the correct path.
REQ-013 `redirect`, output, 1: a control transfer is taken this cycle.

Function
REQ-014 States SHALL be RUN and BUBBLE; `inst_valid` = (state==RUN).
REQ-015 Target selection SHALL follow this priority, evaluated only in RUN:
- jr: `rd_val`
- jp&bex: taken only if `rstatus_nz`, target zero-extended `target`
- jp (no bex, incl. jal): zero-extended `target`
- br: `pc_d`+1+sign-extended `imm`
- otherwise: no transfer
REQ-016 `jp&bex` with `rstatus_nz`=0 SHALL NOT transfer, and lower-priority terms SHALL NOT be considered.
REQ-017 `redirect` SHALL be combinational: RUN & transfer-taken. It SHALL be 0 in BUBBLE, and SHALL be gated by neither `en` nor `reset`.
REQ-018 Action when `en`=1, RUN, redirect:
- `pc`<=target
- `pc_d`<=`pc`
- state<=BUBBLE
REQ-019 Action when `en`=1, RUN, no redirect:
- `pc`<=`pc`+1
- `pc_d`<=`pc`
- state stays RUN
REQ-020 Action when `en`=1, BUBBLE: control inputs are ignored; `pc`<=`pc`+1, `pc_d`<=`pc`, state<=RUN.
REQ-021 When `en`=0, `pc`, `pc_d` and state SHALL hold. `redirect` still reflects the inputs but SHALL cause no update.
REQ-022 All arithmetic SHALL be 32-bit modulo 2^32; `pc`=32'hFFFFFFFF increments to 0 without a flag.
REQ-023 `link` SHALL be combinational from `pc_d` and valid whenever `inst_valid`=1.
REQ-024 Redirect latency SHALL be one bubble: the target instruction reaches decode two enabled cycles after the redirect cycle.

Reset
REQ-025 On `reset`=1 at a clock edge, regardless of `en` or state:
- `pc`<=0
- `pc_d`<=0
- state<=BUBBLE
REQ-026 After reset, `inst_valid`=0 and `redirect`=0 until the first enabled edge.
REQ-027 A reset mid-redirect or mid-stall SHALL discard the pending target.

Structure
REQ-028 A shared package/header SHALL hold:
- the state encoding (RUN, BUBBLE)
- PC width 32, T width 27, N width 17
- link register index 31
REQ-029 Target selection SHALL be one combinational sub-module, `pc_target_sel` (priority mux plus branch adder). The state/PC registers SHALL stay in `pc_sequencer`.

Verification
REQ-030 Reset, then en=1 with no control for 4 cycles -> pc 1,2,3,4; pc_d 0,1,2,3; inst_valid 0,1,1,1.
REQ-031 RUN, pc_d=10, br=1, imm=17'h1FFFD (-3) -> redirect=1; next pc=8, inst_valid=0; next pc=9, pc_d=8, inst_valid=1.
REQ-032 RUN, pc_d=5, jal=1, jp=1, target=27'h100 -> link=6, redirect=1, next pc=32'h100.
REQ-033 Hold jp=1, bex=1 with rstatus_nz=0 and pc_d=7 (next pc=8, no redirect); then rstatus_nz=1, target=40 -> redirect, next pc=40.
REQ-034 Set jr=1, jp=1, bex=1, br=1, rd_val=32'hFFFFFFFF; the redirect edge has en=0, then en=1 -> pc holds across the en=0 edge, then pc=32'hFFFFFFFF, then 0 (wrap).
REQ-035 Set reset=1 on the cycle after a redirect -> pc=0, pc_d=0, inst_valid=0, and the target is discarded.
